m_store_buffer: RTL and testbench
=================================

Name: m_store_buffer

Overview:
- Parametrised successor of the M-stage store-data formatter; sits between M-stage store issue and the data-memory/bridge write port.
- Formats store data and byte enables for a DATA_W-wide bus and detects store address exceptions (AdES) against parametrised address regions.
- Decouples the pipeline from memory with a DEPTH-entry in-order write buffer drained over a req/ack handshake.

Parameters:
- DATA_W, 32, bus width in bits; 32 or 64 only. NB = DATA_W/8 byte lanes, LB = log2(NB).
- DEPTH, 4, buffer entries; power of two, at least 2.
- DM_HI, 32'h0000_2fff, last legal DM byte address (DM region is 0..DM_HI).
- T0_BASE, 32'h0000_7f00, timer0 base address; region is base..base+11, count register at base+8..base+11.
- T1_BASE, 32'h0000_7f10, timer1 base address; same layout as timer0.
- INT_BASE, 32'h0000_7f20, interrupt-generator register; region is base..base+3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  store offered this cycle.
- in_ready  out  1  buffer can accept a store.
- in_op  in  3  0 none, 1 word, 2 half, 3 byte, 4 double; 5-7 treated as none.
- in_addr  in  32  byte address.
- in_data  in  DATA_W  raw store data, right-aligned.
- ades  out  1  address exception for the offered store (combinational).
- mem_req  out  1  head entry valid.
- mem_addr  out  32  head address, low LB bits zero.
- mem_byteen  out  NB  head byte enables.
- mem_wdata  out  DATA_W  head lane-aligned data.
- mem_ack  in  1  memory accepts the head entry this cycle.
- empty  out  1  no entries held.
- count  out  log2(DEPTH)+1  number of held entries.

Behaviour:
- ades = in_valid and in_op in 1..4, and any of the following holds:
  - misaligned: word with addr[1:0]!=0; half with addr[0]; double with addr[2:0]!=0.
  - double with DATA_W=32.
  - half or byte store into either timer region.
  - any store into either timer count register.
  - address outside the DM, T0, T1 and INT regions.
- Formatting: lane = addr[LB-1:0].
  - byteen = (1, 3, 4'hF or 8'hFF for byte, half, word, double) shifted left by lane.
  - wdata = the low 1/2/4/8 bytes of in_data shifted left by 8*lane; all other bits zero.
- in_ready = !full. There is no combinational path from mem_ack to in_ready.
- Push: in_valid && in_ready && in_op in 1..4 && !ades. Excepting stores and op-none stores are dropped; they are never enqueued.
- Pop: mem_req && mem_ack. Outputs come from storage at rd_ptr, so latency from push to mem_req is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full when count==DEPTH; empty when count==0.
- mem_ack while empty is ignored.
- Drain order is strictly FIFO. The memory side must hold mem_addr/byteen/wdata stable until it asserts ack, and the block guarantees they are stable while mem_req is high.
- When empty: mem_req=0, mem_addr=0, mem_byteen=0, mem_wdata=0.
- Reset: pointers=0, count=0, empty=1, mem_req=0, all mem_* outputs 0. Held entries are discarded, including any partial drain. in_ready=1 from the first cycle after reset.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: adds input ld_addr[31:0], outputs ld_hit[NB-1:0] and ld_data[DATA_W-1:0].
  - Entries whose address equals ld_addr with low LB bits cleared are matched combinationally.
  - For each byte lane, the youngest matching entry with that byteen bit set supplies the byte and sets ld_hit.
  - Lanes with no match: ld_hit=0 and data byte 0.
  - An entry being pushed in the same cycle is not visible; an entry popping in the same cycle is still visible.
- Undefined: these ports and all match logic are absent.

Test Plan:
- DATA_W=32, sb at 0x0000_0003 with data 0x1234_56AB -> ades=0. Next cycle: mem_req=1, mem_addr=0x0, mem_byteen=4'b1000, mem_wdata=0xAB00_0000.
- sh at 0x0000_7f04, then sw at 0x0000_7f08, then sw at 0x0000_3000 -> ades=1 for each, count stays 0, mem_req stays 0.
- DATA_W=64, sw at 0x0000_0014 with data 0x0000_0000_DEAD_BEEF -> mem_addr=0x10, mem_byteen=8'hF0, mem_wdata=0xDEAD_BEEF_0000_0000. Double at 0x0000_0004 -> ades=1.
- DEPTH=4, mem_ack held 0, push 5 stores -> in_ready=0 after the 4th, 5th not accepted, count=4. Then push and ack in the same cycle once not full -> count unchanged, FIFO order preserved across pointer wrap.
- Reset asserted with 3 entries held and mem_ack=0 -> next cycle count=0, empty=1, mem_req=0, in_ready=1.
- STORE_FWD_EN, sw 0x1111_2222 then sb 0x33 both at 0x0000_0100, ld_addr=0x100 -> ld_hit=4'hF, ld_data=0x1111_2233.

Source files
------------

// File: rtl/m_store_buffer.sv
// ---------------------------------------------------------------------------
// m_store_buffer
//   M-stage store formatter plus DEPTH-entry in-order write buffer.
//   Formats store data / byte enables for a DATA_W-wide bus, flags store
//   address exceptions (ades) against the DM / timer / interrupt regions and
//   drains accepted stores to memory over a req/ack handshake.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  store offer / buffer has room (in_ready = !full)
//   in_op              0 none, 1 word, 2 half, 3 byte, 4 double, 5-7 none
//   in_addr, in_data   byte address, right-aligned raw store data
//   ades               combinational address exception for the offered store
//   mem_req            head entry valid
//   mem_addr/byteen/wdata  head entry (all zero when empty)
//   mem_ack            memory accepts head entry
//   empty, count       occupancy status
//
// Optional feature (macro STORE_FWD_EN): adds ld_addr / ld_hit / ld_data,
//   a per-byte-lane store-to-load forwarding lookup over the held entries.
// ---------------------------------------------------------------------------
module m_store_buffer #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] DM_HI    = 32'h0000_2fff,
  parameter logic [31:0] T0_BASE  = 32'h0000_7f00,
  parameter logic [31:0] T1_BASE  = 32'h0000_7f10,
  parameter logic [31:0] INT_BASE = 32'h0000_7f20,
  localparam int NB = DATA_W / 8,
  localparam int LB = $clog2(NB),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              ades,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [NB-1:0]     mem_byteen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              empty,
  output logic [PW:0]       count
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0]       ld_addr,
  output logic [NB-1:0]     ld_hit,
  output logic [DATA_W-1:0] ld_data
`endif
);

  localparam logic [31:0] LANE_MASK = 32'(NB - 1);

  // Right-aligned byte-enable pattern for the access size.
  function automatic logic [NB-1:0] base_be(input logic [2:0] op);
    case (op)
      3'd1:    base_be = NB'(4'hF);
      3'd2:    base_be = NB'(2'b11);
      3'd3:    base_be = NB'(1'b1);
      3'd4:    base_be = '1;
      default: base_be = '0;
    endcase
  endfunction

  // Expand byte enables into a bit mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [NB-1:0] be);
    be_to_mask = '0;
    for (int j = 0; j < NB; j++) be_to_mask[8*j +: 8] = {8{be[j]}};
  endfunction

  logic          op_w, op_h, op_b, op_d, op_ok;
  logic [LB-1:0] lane;
  logic          misalign, dbl_bad, in_dm, in_t0, in_t1, in_int, cnt_t0, cnt_t1;
  logic [31:0]       fmt_addr;
  logic [NB-1:0]     fmt_be;
  logic [DATA_W-1:0] fmt_data;
  logic          full, push, pop;

  logic [31:0]       addr_q [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  assign op_w  = (in_op == 3'd1);
  assign op_h  = (in_op == 3'd2);
  assign op_b  = (in_op == 3'd3);
  assign op_d  = (in_op == 3'd4);
  assign op_ok = op_w | op_h | op_b | op_d;
  assign lane  = in_addr[LB-1:0];

  assign misalign = (op_w && in_addr[1:0] != 2'b00) || (op_h && in_addr[0])
                 || (op_d && in_addr[2:0] != 3'b000);
  assign dbl_bad  = op_d && (DATA_W == 32);
  assign in_dm    = (in_addr <= DM_HI);
  assign in_t0    = (in_addr >= T0_BASE) && (in_addr <= T0_BASE + 32'd11);
  assign in_t1    = (in_addr >= T1_BASE) && (in_addr <= T1_BASE + 32'd11);
  assign in_int   = (in_addr >= INT_BASE) && (in_addr <= INT_BASE + 32'd3);
  assign cnt_t0   = (in_addr >= T0_BASE + 32'd8) && (in_addr <= T0_BASE + 32'd11);
  assign cnt_t1   = (in_addr >= T1_BASE + 32'd8) && (in_addr <= T1_BASE + 32'd11);

  assign ades = in_valid && op_ok &&
                (misalign || dbl_bad || ((op_h || op_b) && (in_t0 || in_t1)) ||
                 cnt_t0 || cnt_t1 || !(in_dm || in_t0 || in_t1 || in_int));

  assign fmt_addr = in_addr & ~LANE_MASK;
  assign fmt_be   = base_be(in_op) << lane;
  assign fmt_data = (in_data & be_to_mask(base_be(in_op))) << {lane, 3'b000};

  // in_ready depends only on registered occupancy, never on mem_ack.
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready && op_ok && !ades;
  assign pop      = !empty && mem_ack;

  assign mem_req    = !empty;
  assign mem_addr   = empty ? '0 : addr_q[rd_ptr];
  assign mem_byteen = empty ? '0 : be_q[rd_ptr];
  assign mem_wdata  = empty ? '0 : data_q[rd_ptr];

  // ---- buffer storage (data, no reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= fmt_addr;
      be_q[wr_ptr]   <= fmt_be;
      data_q[wr_ptr] <= fmt_data;
    end
  end

  // ---- pointer / occupancy control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so younger matches overwrite older bytes.
  always_comb begin
    ld_hit  = '0;
    ld_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (i < int'(count) && addr_q[fwd_idx] == (ld_addr & ~LANE_MASK)) begin
        for (int j = 0; j < NB; j++) begin
          if (be_q[fwd_idx][j]) begin
            ld_hit[j]         = 1'b1;
            ld_data[8*j +: 8] = data_q[fwd_idx][8*j +: 8];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_m_store_buffer.sv
module tb_m_store_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, mem_ack;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_data;
  logic        in_ready, ades, mem_req, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic [2:0]  count;

  logic        v64, ack64;
  logic [2:0]  op64;
  logic [31:0] addr64;
  logic [63:0] data64;
  logic        ready64, ades64, req64, empty64;
  logic [31:0] maddr64;
  logic [7:0]  be64;
  logic [63:0] wdata64;
  logic [2:0]  count64;

`ifdef STORE_FWD_EN
  logic [31:0] ld_addr, ld_addr64;
  logic [3:0]  ld_hit;
  logic [31:0] ld_data;
  logic [7:0]  ld_hit64;
  logic [63:0] ld_data64;
`endif

  m_store_buffer #(.DATA_W(32), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .ades(ades),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .empty(empty), .count(count)
`ifdef STORE_FWD_EN
    , .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data)
`endif
  );

  m_store_buffer #(.DATA_W(64), .DEPTH(4)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(ready64),
    .in_op(op64), .in_addr(addr64), .in_data(data64), .ades(ades64),
    .mem_req(req64), .mem_addr(maddr64), .mem_byteen(be64),
    .mem_wdata(wdata64), .mem_ack(ack64), .empty(empty64), .count(count64)
`ifdef STORE_FWD_EN
    , .ld_addr(ld_addr64), .ld_hit(ld_hit64), .ld_data(ld_data64)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference formatter for the 32-bit bus: place `size` bytes starting at lane.
  function automatic exp_t fmt32(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t r;
    int   size, ln;
    size = (op == 3'd1) ? 4 : (op == 3'd2) ? 2 : (op == 3'd3) ? 1 : 0;
    ln   = int'(a[1:0]);
    r.a  = {a[31:2], 2'b00};
    r.be = '0;
    r.d  = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= ln && j < ln + size) begin
        r.be[j]       = 1'b1;
        r.d[8*j +: 8] = d[8*(j-ln) +: 8];
      end
    end
    return r;
  endfunction

  // One clock of the 32-bit DUT with scoreboard bookkeeping.
  task automatic tick(input bit v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d, input bit ack, input bit exp_ades,
                      input string tag);
    int   n0;
    bit   opok;
    exp_t e;
    in_valid = v; in_op = op; in_addr = a; in_data = d; mem_ack = ack;
    #1;
    n0   = sb.size();
    opok = (op >= 3'd1) && (op <= 3'd4);
    chk({tag, ".ades"},  ades, v ? exp_ades : 1'b0);
    chk({tag, ".ready"}, in_ready, n0 < 4);
    chk({tag, ".req"},   mem_req, n0 != 0);
    if (n0 != 0) begin
      e = sb[0];
      chk({tag, ".addr"},  mem_addr, e.a);
      chk({tag, ".be"},    mem_byteen, e.be);
      chk({tag, ".wdata"}, mem_wdata, e.d);
      if (ack) void'(sb.pop_front());
    end else begin
      chk({tag, ".idle_aw"}, {mem_addr, mem_wdata}, 64'h0);
      chk({tag, ".idle_be"}, mem_byteen, 4'h0);
    end
    if (v && opok && !exp_ades && n0 < 4) sb.push_back(fmt32(op, a, d));
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b0;
    chk({tag, ".count"}, count, sb.size());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; mem_ack = 0; in_op = 0; in_addr = 0; in_data = 0;
    v64 = 0; ack64 = 0; op64 = 0; addr64 = 0; data64 = 0;
`ifdef STORE_FWD_EN
    ld_addr = 0; ld_addr64 = 0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst.count", count, 3'd0);
    chk("rst.empty", empty, 1'b1);
    chk("rst.req",   mem_req, 1'b0);
    chk("rst.ready", in_ready, 1'b1);
    chk("rst.addr",  mem_addr, 32'h0);

    // Byte store in the top lane
    tick(1, 3'd3, 32'h0000_0003, 32'h1234_56AB, 0, 0, "sb3");
    chk("sb3.req_c",   mem_req, 1'b1);
    chk("sb3.addr_c",  mem_addr, 32'h0);
    chk("sb3.be_c",    mem_byteen, 4'b1000);
    chk("sb3.wdata_c", mem_wdata, 32'hAB00_0000);
    tick(0, 3'd0, 0, 0, 1, 0, "drain1");

    // Exceptions and dropped ops
    tick(1, 3'd2, 32'h0000_7f04, 32'h0, 0, 1, "sh_t0");
    tick(1, 3'd1, 32'h0000_7f08, 32'h0, 0, 1, "sw_t0cnt");
    tick(1, 3'd1, 32'h0000_3000, 32'h0, 0, 1, "sw_hole");
    tick(1, 3'd1, 32'h0000_0002, 32'h0, 0, 1, "sw_mis");
    tick(1, 3'd2, 32'h0000_0001, 32'h0, 0, 1, "sh_mis");
    tick(1, 3'd4, 32'h0000_0000, 32'h0, 0, 1, "sd_32");
    tick(1, 3'd3, 32'h0000_7f13, 32'h0, 0, 1, "sb_t1");
    tick(1, 3'd1, 32'h0000_7f1c, 32'h0, 0, 1, "sw_t1out");
    tick(1, 3'd3, 32'h0000_7f24, 32'h0, 0, 1, "sb_intout");
    tick(1, 3'd0, 32'h0000_0100, 32'h5, 0, 0, "op_none");
    tick(1, 3'd5, 32'h0000_0100, 32'h5, 0, 0, "op_5");
    tick(0, 3'd0, 0, 0, 1, 0, "ack_empty");

    // Legal region edges, drained as they go
    tick(1, 3'd1, 32'h0000_7f00, 32'hA5A5_0001, 0, 0, "sw_t0ok");
    tick(1, 3'd1, 32'h0000_7f20, 32'hA5A5_0002, 1, 0, "sw_int");
    tick(1, 3'd3, 32'h0000_2fff, 32'h0000_00C3, 1, 0, "sb_dmhi");
    tick(0, 3'd0, 0, 0, 1, 0, "drain2");
    tick(0, 3'd0, 0, 0, 1, 0, "drain3");

    // Fill to full with mixed sizes, 5th rejected
    tick(1, 3'd1, 32'h0000_0200, 32'h1111_0000, 0, 0, "fill0");
    tick(1, 3'd2, 32'h0000_0206, 32'hCAFE_BEEF, 0, 0, "fill1");
    tick(1, 3'd3, 32'h0000_0209, 32'h0000_0077, 0, 0, "fill2");
    tick(1, 3'd1, 32'h0000_020c, 32'h3333_0003, 0, 0, "fill3");
    chk("full.ready", in_ready, 1'b0);
    tick(1, 3'd1, 32'h0000_0210, 32'h4444_0004, 0, 0, "fill4");
    chk("full.count", count, 3'd4);
    tick(0, 3'd0, 0, 0, 1, 0, "pop_full");
    tick(1, 3'd1, 32'h0000_0300, 32'h5555_0005, 1, 0, "push_pop");
    chk("pp.count", count, 3'd3);
    for (int k = 0; k < 3; k++) tick(0, 3'd0, 0, 0, 1, 0, "wrap_drain");
    chk("wrap.empty", empty, 1'b1);

    // Reset with entries held
    tick(1, 3'd1, 32'h0000_0400, 32'h1, 0, 0, "pre_rst0");
    tick(1, 3'd1, 32'h0000_0404, 32'h2, 0, 0, "pre_rst1");
    tick(1, 3'd1, 32'h0000_0408, 32'h3, 0, 0, "pre_rst2");
    do_reset();
    chk("rst2.count", count, 3'd0);
    chk("rst2.empty", empty, 1'b1);
    chk("rst2.req",   mem_req, 1'b0);
    chk("rst2.ready", in_ready, 1'b1);
    tick(1, 3'd1, 32'h0000_0500, 32'h6666_0006, 1, 0, "post_rst");
    tick(0, 3'd0, 0, 0, 1, 0, "post_rst_drain");

    // 64-bit bus
    v64 = 1; op64 = 3'd1; addr64 = 32'h0000_0014; data64 = 64'h0000_0000_DEAD_BEEF;
    #1 chk("w64.ades", ades64, 1'b0);
    @(posedge clk); #1;
    v64 = 0;
    chk("w64.req",   req64, 1'b1);
    chk("w64.addr",  maddr64, 32'h10);
    chk("w64.be",    be64, 8'hF0);
    chk("w64.wdata", wdata64, 64'hDEAD_BEEF_0000_0000);
    v64 = 1; op64 = 3'd4; addr64 = 32'h0000_0004;
    #1 chk("d64mis.ades", ades64, 1'b1);
    addr64 = 32'h0000_0008; data64 = 64'h0123_4567_89AB_CDEF;
    #1 chk("d64.ades", ades64, 1'b0);
    ack64 = 1;
    @(posedge clk); #1;
    v64 = 0; ack64 = 0;
    chk("d64.count", count64, 3'd1);
    chk("d64.addr",  maddr64, 32'h8);
    chk("d64.be",    be64, 8'hFF);
    chk("d64.wdata", wdata64, 64'h0123_4567_89AB_CDEF);

`ifdef STORE_FWD_EN
    do_reset();
    tick(1, 3'd1, 32'h0000_0100, 32'h1111_2222, 0, 0, "fwd_sw");
    tick(1, 3'd3, 32'h0000_0100, 32'h0000_0033, 0, 0, "fwd_sb");
    ld_addr = 32'h0000_0102;
    #1;
    chk("fwd.hit",  ld_hit, 4'hF);
    chk("fwd.data", ld_data, 32'h1111_2233);
    ld_addr = 32'h0000_0104;
    #1;
    chk("fwd.miss_hit",  ld_hit, 4'h0);
    chk("fwd.miss_data", ld_data, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
